asi_usr_mem: RTL and testbench
==============================

# asi_usr_mem

User-side word memory that sits directly downstream of the AXI slave interface `asi`, in the `usr_clk` domain. It consumes the `m_addr`/`m_we`/`m_wdata`/`m_wstrb` memory port and returns `m_rdata` with exactly `SLV_WS` cycles of read latency, matching the wait-state setting `asi` uses to sample read data. It zero-initialises itself after reset with a sweep state machine, and flags out-of-range accesses.

## Interface
- `DEPTH`, 1024: number of `AXI_DW`-bit words; power of two, ≥ 2.
- `SLV_WS`, `asi_pkg::SLV_WS`: read latency in cycles; legal values are 0..4.
- `usr_clk  in  1`: single clock; every flop in the block uses it.
- `usr_reset  in  1`: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `m_addr  in  AXI_AW`: byte address of the access.
- `m_we  in  1`: write enable.
- `m_wdata  in  AXI_DW`: write data.
- `m_wstrb  in  AXI_WSTRBW`: byte enables.
- `m_rdata  out  AXI_DW`: read data, `SLV_WS` cycles after the address.
- `init_done  out  1`: 1 once the zero sweep has completed.
- `wr_drop  out  1`: one-cycle pulse when a write is discarded.
- `oor_err  out  1`: one-cycle pulse on any access outside the memory range.
- `par_err  out  1`: sticky parity error flag. Present only with `ASI_MEM_PARITY_EN`.
- `pe_inject  in  1`: when 1 during a write, inverts the stored parity bits. Present only with `ASI_MEM_PARITY_EN`.

## Operation
- **Address mapping**
  - `OFS = log2(AXI_DW/8)`; word index `idx = m_addr[OFS +: log2(DEPTH)]`.
  - An access is in range iff `m_addr >> OFS < DEPTH`. Low `OFS` bits are ignored, so unaligned addresses are word-truncated.
- **State machine:** `INIT` → `RUN`.
  - Reset forces `INIT` and sets `clr_ptr` = 0.
  - `INIT`: each cycle writes all-zero data (plus zero parity) to `mem[clr_ptr]`, then `clr_ptr++`. The write of index `DEPTH-1` moves the FSM to `RUN` on the next edge.
  - `RUN` is terminal until the next reset.
- **Writes**
  - In `RUN`, with `m_we`=1 and in range: `mem[idx]` byte k ← `m_wdata` byte k for every k with `m_wstrb[k]`=1; other bytes are unchanged.
  - `m_wstrb`=0 is a legal no-op.
  - In `INIT`, `m_we`=1 pulses `wr_drop` and does not modify the array.
- **Reads:** the array is read at `idx` every cycle regardless of `m_we`. Read-before-write: a same-cycle write is not visible in that read.
- **Out of range**
  - Writes are ignored.
  - Read data is 0.
  - `oor_err` pulses in the access cycle (registered; it appears on the following edge). It also pulses on an out-of-range write in `INIT`, together with `wr_drop`.
- **Gating:** `m_rdata` is 0 for any read captured while in `INIT`.

## Timing
- **Reset values:**
  - `m_rdata` = 0 and all read-pipeline stages = 0.
  - `init_done` = 0, `wr_drop` = 0, `oor_err` = 0, `par_err` = 0.
- **Init duration:** `init_done` rises exactly `DEPTH` cycles after the first edge with `usr_reset` = 0. It then stays 1 until reset.
- **`SLV_WS` = 0:** `m_rdata` is combinational from `m_addr`, producing `mem[idx]` in the same cycle. The array must therefore be an asynchronous-read flop array.
- **`SLV_WS` = N ≥ 1:**
  - Stage 1 registers `mem[idx]`, already gated for range and `INIT`.
  - N-1 further register stages follow, and `m_rdata` is the last stage.
  - A write to `idx` at or after the capture cycle does not change data already in flight.
- **Reset mid-operation:** pipeline contents are cleared and the sweep restarts from index 0. Prior array contents are overwritten by the sweep.
- **Counter behaviour:** `clr_ptr` is `log2(DEPTH)` bits and does not wrap into `RUN` early. The terminal compare is on `clr_ptr == DEPTH-1`.
- **Pulse outputs:** `wr_drop` and `oor_err` are registered, one cycle late, with no coalescing. Back-to-back events give back-to-back pulses.

## Configuration
- **`ASI_MEM_PARITY_EN` defined:**
  - Each byte stores an even-parity bit, updated only for strobed bytes.
  - `pe_inject` inverts the parity bits written in that cycle.
  - Parity is checked for all bytes on every in-range read in `RUN`, in stage 1 (or combinationally when `SLV_WS` = 0, registered into the flag).
  - A mismatch sets `par_err` on the next edge; it clears only on reset.
  - The `INIT` sweep writes zero parity.
- **Not defined:**
  - No parity storage or check logic.
  - The `par_err` and `pe_inject` ports do not exist.

## Test plan
- **Init sweep:** `DEPTH`=16. Release reset → `init_done` rises after exactly 16 cycles. A write of 0xDEADBEEF to addr 0x4 at cycle 3 → `wr_drop` pulse; a later read of 0x4 returns 0.
- **Latency:** `SLV_WS`=2, 32-bit data, in `RUN`. Write 0x12345678 to 0x8, then read 0x8 → `m_rdata`=0x12345678 exactly 2 cycles after the address cycle, and 0 before that.
- **Byte strobes:** write 0xFFFFFFFF, then 0x00000000 with `m_wstrb`=4'b0101 to 0xC → read returns 0xFF00FF00.
- **Out of range:** `DEPTH`=16, 32-bit data. Write to 0x40 → `oor_err` pulse and no array change (a read of 0x0 is unchanged). A read of 0x40 → 0 plus an `oor_err` pulse.
- **Reset mid-sweep and mid-read:** assert reset while a read is in flight and `clr_ptr`=5 → `m_rdata`=0 next cycle, `init_done`=0, and the sweep restarts to a full `DEPTH` count.
- **Parity (`ASI_MEM_PARITY_EN`):** write 0xA5 to 0x0 with `pe_inject`=1, then read 0x0 → `par_err` rises and stays 1 until reset. Clean writes and reads leave it 0.

Source files
------------

// File: rtl/asi_usr_mem_if.sv
// Memory-port bundle between the asi slave (master side) and asi_usr_mem (slave side).
interface asi_usr_mem_if #(
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 32
);
    localparam int AXI_WSTRBW = AXI_DW / 8;

    logic [AXI_AW-1:0]     m_addr;
    logic                  m_we;
    logic [AXI_DW-1:0]     m_wdata;
    logic [AXI_WSTRBW-1:0] m_wstrb;
    logic [AXI_DW-1:0]     m_rdata;

    modport master (output m_addr, m_we, m_wdata, m_wstrb, input m_rdata);
    modport slave  (input m_addr, m_we, m_wdata, m_wstrb, output m_rdata);
endinterface

// File: rtl/asi_usr_mem.sv
// User-side word memory behind asi: zero sweep after reset, SLV_WS-cycle reads, range flags.
// Optional per-byte even parity with a sticky error flag when ASI_MEM_PARITY_EN is defined.
module asi_usr_mem #(
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 32,
    parameter int DEPTH  = 1024,
    parameter int SLV_WS = 2
) (
    input  logic         usr_clk,
    input  logic         usr_reset,
    asi_usr_mem_if.slave m,
    output logic         init_done,
    output logic         wr_drop,
    output logic         oor_err
`ifdef ASI_MEM_PARITY_EN
    ,
    output logic         par_err,
    input  logic         pe_inject
`endif
);
    localparam int NB  = AXI_DW / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     clr_ptr_q, clr_ptr_d;
    logic              is_run, sweep_en;

    logic [AXI_AW-1:0] word_addr;
    logic [IW-1:0]     idx;
    logic              in_range;

    logic [AXI_DW-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [AXI_DW-1:0] wr_data;
    logic [NB-1:0]     wr_mask;

    logic [AXI_DW-1:0] rd_word, rd_gated;
    logic              wr_drop_q, wr_drop_d;
    logic              oor_err_q, oor_err_d;

    // Low OFS bits drop out of the shift, so unaligned addresses truncate to the word.
    always_comb begin
        word_addr = m.m_addr >> OFS;
        idx       = word_addr[IW-1:0];
        in_range  = word_addr < AXI_AW'(DEPTH);
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + IW'(1);
            if (clr_ptr_q == IW'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    always_comb begin
        is_run    = (state_q == ST_RUN);
        sweep_en  = (state_q == ST_INIT) && !usr_reset;
        init_done = is_run;
    end

    // Single write port shared by the zero sweep and user writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_data = m.m_wdata;
        wr_mask = m.m_wstrb;
        if (sweep_en) begin
            wr_en   = 1'b1;
            wr_idx  = clr_ptr_q;
            wr_data = '0;
            wr_mask = '1;
        end else if (!usr_reset && is_run && m.m_we && in_range) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) mem_q[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
        end
    end

    // Asynchronous read sees the pre-edge contents, giving read-before-write.
    always_comb begin
        rd_word  = mem_q[idx];
        rd_gated = (is_run && in_range) ? rd_word : '0;
    end

    generate
        if (SLV_WS == 0) begin : g_comb
            assign m.m_rdata = rd_gated;
        end else begin : g_pipe
            logic [AXI_DW-1:0] rd_pipe_q [SLV_WS];
            logic [AXI_DW-1:0] rd_pipe_d [SLV_WS];

            always_comb begin
                rd_pipe_d[0] = rd_gated;
                for (int s = 1; s < SLV_WS; s++) rd_pipe_d[s] = rd_pipe_q[s-1];
            end

            always_ff @(posedge usr_clk) begin
                for (int s = 0; s < SLV_WS; s++) begin
                    if (usr_reset) rd_pipe_q[s] <= '0;
                    else           rd_pipe_q[s] <= rd_pipe_d[s];
                end
            end

            assign m.m_rdata = rd_pipe_q[SLV_WS-1];
        end
    endgenerate

    always_comb begin
        wr_drop_d = !is_run && m.m_we;
        oor_err_d = !in_range;
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            wr_drop_q <= 1'b0;
            oor_err_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
            oor_err_q <= oor_err_d;
        end
    end

    assign wr_drop = wr_drop_q;
    assign oor_err = oor_err_q;

`ifdef ASI_MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par;
    logic          par_bad;
    logic          par_err_q, par_err_d;

    function automatic logic [NB-1:0] byte_par(input logic [AXI_DW-1:0] d);
        logic [NB-1:0] p;
        for (int k = 0; k < NB; k++) p[k] = ^d[k*8 +: 8];
        return p;
    endfunction

    always_comb begin
        wr_par = byte_par(wr_data);
        if (!sweep_en && pe_inject) wr_par = ~wr_par;
    end

    always_ff @(posedge usr_clk) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) par_q[wr_idx][k] <= wr_par[k];
            end
        end
    end

    // Checked on the capture cycle; the flag is sticky until reset.
    always_comb begin
        par_bad   = is_run && in_range && (byte_par(rd_word) != par_q[idx]);
        par_err_d = par_err_q | par_bad;
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) par_err_q <= 1'b0;
        else           par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;
`endif
endmodule

// File: tb/tb_asi_usr_mem.sv
// Randomised scoreboard bench for asi_usr_mem (DEPTH=16, SLV_WS=2, 32-bit data).
module tb_asi_usr_mem;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int WS    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done, wr_drop, oor_err;
    logic inj_drv = 1'b0;
`ifdef ASI_MEM_PARITY_EN
    logic par_err;
`endif

    asi_usr_mem_if #(.AXI_AW(AW), .AXI_DW(DW)) bus ();

    asi_usr_mem #(.AXI_AW(AW), .AXI_DW(DW), .DEPTH(DEPTH), .SLV_WS(WS)) dut (
        .usr_clk   (clk),
        .usr_reset (rst),
        .m         (bus),
        .init_done (init_done),
        .wr_drop   (wr_drop),
        .oor_err   (oor_err)
`ifdef ASI_MEM_PARITY_EN
        ,
        .par_err   (par_err),
        .pe_inject (inj_drv)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [31:0] rd; } rd_exp_t;
    typedef struct { int due; logic drop; logic oor; logic done; logic par; } pl_exp_t;

    rd_exp_t     q_rd[$];
    pl_exp_t     q_pl[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    int          rel    = 0;
    logic [31:0] model     [DEPTH];
    logic [3:0]  model_bad [DEPTH];
    logic        par_model = 1'b0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endfunction

    // Issue one access for the coming edge and queue what the DUT must show for it.
    task automatic step(input logic r, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [3:0] st, input logic inj);
        rd_exp_t er;
        pl_exp_t ep;
        int      n, idx;
        logic    run, inr;
        @(negedge clk);
        rst = r; bus.m_addr = a; bus.m_we = we; bus.m_wdata = wd; bus.m_wstrb = st;
        inj_drv = inj;
        n   = cyc + 1;
        run = !r && (rel >= DEPTH);
        inr = (a >> 2) < DEPTH;
        idx = int'((a >> 2) % DEPTH);
        if (r) begin
            foreach (q_rd[i]) if (q_rd[i].due >= n) q_rd[i].rd = '0;
            par_model = 1'b0;
        end else if (run && inr && model_bad[idx] != 4'h0) begin
            par_model = 1'b1;
        end
        er.due  = n + WS - 1;
        er.rd   = (run && inr) ? model[idx] : 32'h0;
        ep.due  = n;
        ep.drop = !r && !run && we;
        ep.oor  = !r && !inr;
        ep.done = !r && (rel + 1 >= DEPTH);
        ep.par  = par_model;
        if (r) begin
            rel = 0;
            foreach (model[i]) begin model[i] = '0; model_bad[i] = '0; end
        end else begin
            if (run && inr && we) begin
                for (int k = 0; k < 4; k++) begin
                    if (st[k]) begin
                        model[idx][k*8 +: 8] = wd[k*8 +: 8];
                        model_bad[idx][k]    = inj;
                    end
                end
            end
            rel++;
        end
        q_rd.push_back(er);
        q_pl.push_back(ep);
    endtask

    task automatic idle(input logic [31:0] a);
        step(1'b0, a, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        step(1'b0, a, 1'b1, d, st, 1'b0);
    endtask

    always @(posedge clk) begin
        pl_exp_t ep;
        rd_exp_t er;
        #1;
        cyc++;
        while (q_pl.size() > 0 && q_pl[0].due == cyc) begin
            ep = q_pl.pop_front();
            chk("wr_drop",   32'(wr_drop),   32'(ep.drop));
            chk("oor_err",   32'(oor_err),   32'(ep.oor));
            chk("init_done", 32'(init_done), 32'(ep.done));
`ifdef ASI_MEM_PARITY_EN
            chk("par_err",   32'(par_err),   32'(ep.par));
`endif
        end
        while (q_rd.size() > 0 && q_rd[0].due == cyc) begin
            er = q_rd.pop_front();
            chk("m_rdata", bus.m_rdata, er.rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rdd;
        logic [3:0]  rs;
        bus.m_addr = '0; bus.m_we = 1'b0; bus.m_wdata = '0; bus.m_wstrb = '0;
        repeat (3) step(1'b1, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);

        // Sweep: dropped writes during INIT, one of them out of range.
        for (int i = 0; i < 18; i++) begin
            if (i == 2)      wr(32'h4, 32'hDEADBEEF, 4'hF);
            else if (i == 6) wr(32'h40, 32'h11111111, 4'hF);
            else             idle(32'h4);
        end
        idle(32'h4);

        wr(32'h8, 32'h12345678, 4'hF);
        idle(32'h8);
        idle(32'h0);
        wr(32'hC, 32'hFFFFFFFF, 4'hF);
        wr(32'hC, 32'h00000000, 4'b0101);
        wr(32'hC, 32'h77777777, 4'h0);
        idle(32'hC);
        idle(32'hF);

        wr(32'h0, 32'hCAFEF00D, 4'hF);
        wr(32'h40, 32'hBAD0BAD0, 4'hF);
        idle(32'h0);
        idle(32'h40);
        idle(32'h3C);
        idle(32'h44);

`ifdef ASI_MEM_PARITY_EN
        step(1'b0, 32'h0, 1'b1, 32'h000000A5, 4'b0001, 1'b1);
        idle(32'h0);
        repeat (3) idle(32'h4);
`endif

        // Reset with non-zero data in flight.
        idle(32'h8);
        step(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0);
        repeat (5) idle(32'h8);
        step(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(32'h8);

        for (int i = 0; i < 400; i++) begin
            ra  = 32'($urandom_range(0, 79));
            rdd = $urandom;
            rs  = 4'($urandom);
            if (i == 200) step(1'b1, ra, 1'b0, rdd, rs, 1'b0);
            else step(1'b0, ra, 1'($urandom_range(0, 1)), rdd, rs, ($urandom_range(0, 7) == 0));
        end

        repeat (WS + 2) idle(32'h0);
        repeat (WS + 2) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q_rd.size() + q_pl.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
